// File: rtl/riscv_pkg.sv
// +--------------------------------------------------------------------+
// | riscv_pkg : shared widths and the fetch-queue entry type            |
// | Revision  : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

package riscv_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fq_entry_t;

endpackage

`default_nettype wire

// File: rtl/fq_fifo.sv
// +--------------------------------------------------------------------+
// | fq_fifo  : synchronous FIFO with push/pop/flush, count and head     |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module fq_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [WIDTH-1:0]           head_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != FULL) || do_pop);

    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (flush_i) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            if (do_pop) begin
                rd_d = (rd_q == LAST) ? '0 : rd_q + PW'(1);
            end
            if (do_push) begin
                wr_d = (wr_q == LAST) ? '0 : wr_q + PW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = (count_q != '0) ? mem_q[rd_q] : '0;

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// +--------------------------------------------------------------------+
// | fetch_queue : sequential instruction prefetch with redirect flush   |
// | Option      : FETCH_QUEUE_BYPASS_EN enables empty-queue bypass      |
// | Revision    : 1.0                                                   |
// +--------------------------------------------------------------------+
`default_nettype none

module fetch_queue
    import riscv_pkg::*;
#(
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = 64'h0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc
);

    localparam int          CW      = $clog2(DEPTH + 1);
    localparam int          OW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);
    localparam logic [31:0] MAXO_U  = 32'(MAX_OUTSTANDING);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [OW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   count;
    logic [OW-1:0]   outstanding;
    logic [XLEN-1:0] pend_pc;
    fq_entry_t       entry_in, head;
    logic            grant, rsp, keep, bypass, push, pop;

    // Responses with nothing outstanding are protocol violations and are ignored.
    assign rsp  = imem_rvalid && (outstanding != '0);
    assign keep = rsp && (discard_q == '0);

    assign imem_req  = rst && !redirect_valid
                     && (32'(outstanding) < MAXO_U)
                     && ((32'(count) + 32'(outstanding)) < DEPTH_U);
    assign imem_addr = fetch_pc_q;
    assign grant     = imem_req && imem_gnt;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = (count == '0) && keep && !redirect_valid;
`else
    assign bypass = 1'b0;
`endif

    assign entry_in = '{pc: pend_pc, instr: imem_rdata};
    assign push     = keep && !(bypass && out_ready);
    assign pop      = out_ready && (count != '0);

    assign out_valid = (count != '0) || bypass;
    assign out_instr = bypass ? imem_rdata : head.instr;
    assign out_pc    = bypass ? pend_pc : head.pc;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        if (redirect_valid) begin
            // Everything still in flight after this edge belongs to the old path.
            fetch_pc_d = redirect_pc & ALIGN_MASK;
            discard_d  = outstanding - OW'(rsp);
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (rsp && (discard_q != '0)) begin
                discard_d = discard_q - OW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC & ALIGN_MASK;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
        end
    end

    fq_fifo #(
        .WIDTH ($bits(fq_entry_t)),
        .DEPTH (DEPTH)
    ) u_entry_q (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .data_i  (entry_in),
        .count_o (count),
        .head_o  (head)
    );

    fq_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pend_q (
        .clk     (clk),
        .rst     (rst),
        .push_i  (grant),
        .pop_i   (rsp),
        .flush_i (1'b0),
        .data_i  (fetch_pc_q),
        .count_o (outstanding),
        .head_o  (pend_pc)
    );

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// +--------------------------------------------------------------------+
// | tb_fetch_queue : self-checking bench with a queue-level model       |
// | Revision       : 1.0                                                |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_fetch_queue;

    localparam int          DEPTH = 4;
    localparam int          MAXO  = 2;
    localparam logic [63:0] RPC   = 64'h1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [63:0] out_pc;

    fetch_queue #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO),
        .RESET_PC        (RPC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int          due;
        bit          stale;
    } bus_t;

    bus_t         bus[$];   // granted requests not yet answered, oldest first
    logic [63:0]  mq[$];    // PCs that decode should see next, in order
    logic [63:0]  nf;       // next sequential fetch address
    int           cyc, mem_lat, lat_max, grants;
    int           checks, errors;
    logic [161:0] exp_vec, obs_vec;
    logic         obs_req, obs_valid;
    logic [63:0]  obs_addr, obs_pc;
    logic [31:0]  obs_instr;
    logic [63:0]  xq[$];
    int           xc[$];

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[33:2] ^ {a[63:48], 16'hC0DE} ^ 32'h0000_0013;
    endfunction

    // One clock: drive at negedge, sample 1ns later, advance model at posedge.
    task automatic cycle(input bit gnt, input bit rdy, input bit redir, input logic [63:0] rpc);
        bit          rv, er, ev, byp, gr;
        logic [63:0] epc;
        bus_t        e, n;
        rv = (bus.size() > 0) && (bus[0].due <= cyc);
        imem_gnt       = gnt;
        out_ready      = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_rvalid    = rv;
        imem_rdata     = rv ? mem_word(bus[0].addr) : $urandom;
        assert (!imem_rvalid || bus.size() != 0) else $error("protocol: rvalid with nothing outstanding");
        er  = !redir && (bus.size() < MAXO) && ((mq.size() + bus.size()) < DEPTH);
        byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = (mq.size() == 0) && rv && !bus[0].stale && !redir;
`endif
        ev  = (mq.size() > 0) || byp;
        epc = (mq.size() > 0) ? mq[0] : (byp ? bus[0].addr : 64'h0);
        exp_vec = {er, er ? nf : 64'h0, ev, ev ? epc : 64'h0, ev ? mem_word(epc) : 32'h0};
        #1;
        obs_req   = imem_req;
        obs_addr  = imem_addr;
        obs_valid = out_valid;
        obs_pc    = out_pc;
        obs_instr = out_instr;
        obs_vec = {imem_req, imem_req ? imem_addr : 64'h0, out_valid,
                   out_valid ? out_pc : 64'h0, out_valid ? out_instr : 32'h0};
        if (out_valid && rdy) begin
            xq.push_back(out_pc);
            xc.push_back(cyc);
        end
        if (obs_req && gnt) grants++;
        @(posedge clk);
        gr = er && gnt;
        if (rv) e = bus.pop_front();
        if (redir) begin
            mq.delete();
            foreach (bus[i]) bus[i].stale = 1'b1;
            nf = rpc & ~64'h3;
        end else begin
            if ((mq.size() > 0) && rdy) mq.delete(0);
            if (rv && !e.stale && !(byp && rdy)) mq.push_back(e.addr);
            if (gr) begin
                n.addr  = nf;
                n.due   = cyc + $urandom_range(lat_max, mem_lat);
                n.stale = 1'b0;
                bus.push_back(n);
                nf = nf + 64'd4;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.delete();
        mq.delete();
        xq.delete();
        xc.delete();
        nf = RPC;
        cyc = 0;
        grants = 0;
        mem_lat = 1;
        lat_max = 1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 64'h0);
        rst = 1'b0;
        #1;
        checks++;
        if ({imem_req, out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ctrl got req=%b valid=%b exp 0 0", imem_req, out_valid);
        end
        checks++;
        if ({out_pc, out_instr} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data got pc=%h instr=%h exp 0 0", out_pc, out_instr);
        end
        do_reset();
        cycle(1'b0, 1'b1, 1'b0, 64'h0);
        checks++;
        if (!(obs_req === 1'b1 && obs_addr === RPC && obs_valid === 1'b0)) begin
            errors++;
            $display("FAIL reset_first got req=%b addr=%h valid=%b exp 1 %h 0", obs_req, obs_addr, obs_valid, RPC);
        end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 64'h0);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL stream_model cyc=%0d got %h exp %h", cyc, obs_vec, exp_vec);
            end
        end
        checks++;
        if (xq.size() < 3 || xq[0] !== 64'h1000 || xq[1] !== 64'h1004 || xq[2] !== 64'h1008
            || xc[0] != 2 || xc[1] != 3 || xc[2] != 4) begin
            errors++;
            $display("FAIL stream_seq got n=%0d pc0=%h at %0d exp 1000/1004/1008 at 2/3/4",
                     xq.size(), (xq.size() > 0) ? xq[0] : 64'h0, (xc.size() > 0) ? xc[0] : -1);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 64'h0);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL bp_hold_model cyc=%0d got %h exp %h", cyc, obs_vec, exp_vec);
            end
        end
        checks++;
        if (grants != 4 || obs_req !== 1'b0) begin
            errors++;
            $display("FAIL bp_grants got %0d req=%b exp 4 0", grants, obs_req);
        end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 64'h0);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL bp_drain_model cyc=%0d got %h exp %h", cyc, obs_vec, exp_vec);
            end
        end
        checks++;
        if (xq.size() < 5 || xq[0] !== 64'h1000 || xq[1] !== 64'h1004 || xq[2] !== 64'h1008
            || xq[3] !== 64'h100C || grants <= 4) begin
            errors++;
            $display("FAIL bp_drain got n=%0d grants=%0d exp >=5 outputs from 1000 and >4 grants",
                     xq.size(), grants);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        mem_lat = 4;
        lat_max = 4;
        cycle(1'b1, 1'b1, 1'b0, 64'h0);
        cycle(1'b1, 1'b1, 1'b0, 64'h0);
        cycle(1'b1, 1'b1, 1'b1, 64'h2002);
        checks++;
        if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL redir_cycle got %h exp %h", obs_vec, exp_vec);
        end
        xq.delete();
        for (int i = 0; i < 20 && xq.size() == 0; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 64'h0);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL redir_model cyc=%0d got %h exp %h", cyc, obs_vec, exp_vec);
            end
        end
        checks++;
        if (xq.size() == 0 || xq[0] !== 64'h2000) begin
            errors++;
            $display("FAIL redir_target got n=%0d pc=%h exp 2000", xq.size(), (xq.size() > 0) ? xq[0] : 64'h0);
        end
    endtask

    task automatic test_gnt_stall();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 64'h0);
            checks++;
            if (!(obs_req === 1'b1 && obs_addr === RPC)) begin
                errors++;
                $display("FAIL stall_stable got req=%b addr=%h exp 1 %h", obs_req, obs_addr, RPC);
            end
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 64'h0);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL stall_model cyc=%0d got %h exp %h", cyc, obs_vec, exp_vec);
            end
        end
        checks++;
        if (xq.size() < 2 || xq[0] !== 64'h1000 || xq[1] !== 64'h1004) begin
            errors++;
            $display("FAIL stall_nodup got n=%0d pc0=%h exp 1000 then 1004", xq.size(), (xq.size() > 0) ? xq[0] : 64'h0);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        cycle(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 64'h0);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL wrap_model cyc=%0d got %h exp %h", cyc, obs_vec, exp_vec);
            end
        end
        checks++;
        if (xq.size() < 2 || xq[0] !== 64'hFFFF_FFFF_FFFF_FFFC || xq[1] !== 64'h0) begin
            errors++;
            $display("FAIL wrap_pc got n=%0d pc1=%h exp FFFFFFFFFFFFFFFC then 0", xq.size(), (xq.size() > 1) ? xq[1] : 64'h0);
        end
    endtask

`ifdef FETCH_QUEUE_BYPASS_EN
    task automatic test_bypass();
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 64'h0);
        cycle(1'b0, 1'b1, 1'b0, 64'h0);
        checks++;
        if (!(obs_valid === 1'b1 && obs_pc === RPC && obs_instr === mem_word(RPC))) begin
            errors++;
            $display("FAIL bypass_same got valid=%b pc=%h instr=%h exp 1 %h %h", obs_valid, obs_pc, obs_instr, RPC, mem_word(RPC));
        end
        cycle(1'b0, 1'b1, 1'b0, 64'h0);
        checks++;
        if (obs_valid !== 1'b0) begin
            errors++;
            $display("FAIL bypass_nowrite got valid=%b exp 0", obs_valid);
        end
    endtask
`endif

    task automatic test_random();
        bit          g, r, d;
        logic [63:0] p;
        do_reset();
        mem_lat = 1;
        lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            g = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 9) < 6);
            d = ($urandom_range(0, 99) < 3);
            p = {$urandom, $urandom};
            cycle(g, r, d, p);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL random_model cyc=%0d got %h exp %h", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_gnt_stall();
        test_wrap();
`ifdef FETCH_QUEUE_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue between instruction memory and the core's fetch/decode path. It issues sequential 4-byte fetch requests over a req/gnt/rvalid bus and tracks outstanding responses. Returned instructions are buffered with their PCs and handed to decode via valid/ready. A redirect (branch/jump/trap) flushes queued entries and discards in-flight responses.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `MAX_OUTSTANDING`, 2: maximum granted-but-unreturned requests; ≥1.
- `RESET_PC`, 64'h0: first fetch address after reset.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-low reset (0 = reset asserted).
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 64: fetch address; bits [1:0] always 0.
- `imem_gnt` in 1: request accepted this cycle when `imem_req` is also 1.
- `imem_rvalid` in 1: response valid; responses return in request order.
- `imem_rdata` in 32: instruction word.
- `redirect_valid` in 1: single-cycle redirect strobe.
- `redirect_pc` in 64: new fetch address; bits [1:0] ignored (treated as 0).
- `out_valid` out 1: instruction available to decode.
- `out_ready` in 1: decode accepts; transfer on `out_valid & out_ready`.
- `out_instr` out 32: instruction word.
- `out_pc` out 64: address of `out_instr`.

## Operation
- State:
  - `fetch_pc` (64b).
  - `count` (0..DEPTH).
  - `outstanding` (0..MAX_OUTSTANDING).
  - `discard` (0..MAX_OUTSTANDING).
  - Entry FIFO of {pc, instr}.
  - Pending-PC FIFO of MAX_OUTSTANDING entries.
- Issue:
  - `imem_req = !redirect_valid && outstanding < MAX_OUTSTANDING && count + outstanding < DEPTH`.
  - `imem_addr = fetch_pc`.
- Grant (`imem_req & imem_gnt`):
  - push `fetch_pc` to the pending-PC FIFO.
  - `fetch_pc += 4` (wraps modulo 2^64).
  - `outstanding++`.
- Response (`imem_rvalid`):
  - pop the pending-PC FIFO and `outstanding--`.
  - If `discard > 0`: drop the word and decrement `discard`.
  - Otherwise: push {popped pc, `imem_rdata`} to the entry FIFO.
- Output:
  - `out_valid = count != 0`.
  - `out_instr`/`out_pc` come from the FIFO head.
  - A transfer pops the head.
- Redirect, which has priority over all other updates:
  - `fetch_pc <= {redirect_pc[63:2], 2'b00}`.
  - `count` and FIFO pointers clear.
  - `discard <=` the post-cycle outstanding value, i.e. outstanding plus any grant this cycle minus any rvalid this cycle.
  - A grant in the redirect cycle cannot occur, because `imem_req` is 0.
  - A pop in the redirect cycle is irrelevant, since the queue is cleared.
- Credit rule: `count + outstanding ≤ DEPTH` always, so a non-discarded response always has space. Simultaneous push and pop at `count == DEPTH-1` or at full is legal.
- Bus protocol:
  - The memory may only see `imem_addr` change after a grant or in a redirect cycle.
  - `imem_req` may drop ungranted only in a redirect cycle.
- Protocol violations:
  - `imem_rvalid` while `outstanding == 0` is ignored.
  - The bench flags it with an assertion.

## Timing
- Reset (`rst` = 0):
  - `imem_req` = 0.
  - `fetch_pc = RESET_PC`.
  - `count`, `outstanding` and `discard` = 0.
  - `out_valid` = 0, `out_instr` = 0, `out_pc` = 0.
- Reset released: `imem_req` = 1 in the first active cycle, with `imem_addr = RESET_PC`.
- Reset mid-operation clears all state immediately; later responses from the old transactions are the memory's responsibility to squash.
- Latency: rvalid at edge N → `out_valid` in cycle N+1 (no bypass).
- Throughput: 1 instr/cycle when `MAX_OUTSTANDING` ≥ memory latency + 1 and decode is always ready.
- Redirect at edge N → new-address `imem_req` in cycle N+1; `out_valid` = 0 in cycle N+1.

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined: when `count == 0` and a non-discarded rvalid arrives:
  - `out_valid` = 1 in the same cycle, with `out_instr = imem_rdata` and `out_pc` = pending-FIFO head.
  - If `out_ready` is 1, the entry is not written.
  - Otherwise it is written as normal.
  - Bypass is suppressed in a redirect cycle.
- Undefined: no combinational path from `imem_*` to `out_*`; one-cycle minimum latency.

## Structure
- Shared package `riscv_pkg`:
  - `XLEN` = 64, `ILEN` = 32.
  - `fq_entry_t` struct {logic [XLEN-1:0] pc; logic [ILEN-1:0] instr;}.
- Sub-module `fq_fifo`: generic synchronous FIFO (params WIDTH, DEPTH; push/pop/flush, count, head). Instantiated twice:
  - once as the entry queue.
  - once as the pending-PC FIFO, which has no flush.

## Test plan
- Reset, `RESET_PC` = 64'h1000, gnt always 1, 1-cycle memory, `out_ready` = 1 → `out_pc` sequence 0x1000, 0x1004, 0x1008 at 1/cycle; instructions match memory.
- `out_ready` held 0, DEPTH = 4 → exactly 4 grants issued, then `imem_req` = 0. Release `out_ready` → 4 in-order outputs, and requests resume.
- 2 outstanding requests, then `redirect_valid` with `redirect_pc` = 0x2002 → both old responses dropped; next output `out_pc` = 0x2000.
- `gnt` withheld 3 cycles → `imem_req` and `imem_addr` stay stable; no duplicate fetch.
- `fetch_pc` = 64'hFFFF_FFFF_FFFF_FFFC → next `out_pc` wraps to 0.
- Under `FETCH_QUEUE_BYPASS_EN` with the queue empty → `out_valid` rises in the rvalid cycle with `out_instr = imem_rdata`; `count` stays 0 when `out_ready` = 1.
